// File: rtl/range_sensor_core.sv
// -----------------------------------------------------------------------------
// range_sensor_core
//
// Ultrasonic range-sensor controller. On a start command it drives a trigger
// pulse to the sensor, waits for the echo to rise, and measures how many clk
// cycles the echo stays high. A single timeout counter covers the wait for the
// echo rise and the echo high time together. In repeat mode the block re-fires
// after a fixed hold-off gap until repeat is cleared.
//
// Register map (addr):
//   0 R : status {29'b0, timeout, done, busy}
//   1 R : width, echo high time in clk cycles
//   2 W : ctrl; bit0 = start (self-clearing), bit1 = repeat enable (sticky)
//   3 W : any value clears done and timeout
//   other addresses read 0 and ignore writes
//
// Ports:
//   clk      system clock (single clock domain)
//   reset    synchronous, active-high reset
//   cs       slot select; qualifies write and read
//   write    write strobe
//   read     read strobe (no side effects; rd_data is valid whenever addressed)
//   addr     register address
//   wr_data  write data
//   rd_data  read data, combinational on addr
//   trig_o   trigger pin to the sensor
//   echo_i   echo pin from the sensor, asynchronous to clk
// -----------------------------------------------------------------------------
module range_sensor_core #(
  parameter int unsigned TRIG_CYCLES    = 1000,
  parameter int unsigned TIMEOUT_CYCLES = 3_000_000,
  parameter int unsigned HOLDOFF_CYCLES = 6_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        write,
  input  logic        read,
  input  logic [2:0]  addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        trig_o,
  input  logic        echo_i
);

  localparam logic [31:0] TRIG_LAST    = 32'(TRIG_CYCLES - 1);
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] HOLDOFF_LAST = 32'(HOLDOFF_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_RISE,
    MEASURE,
    HOLDOFF
  } state_t;

  state_t      state;
  state_t      state_next;

  logic        echo_meta;
  logic        echo_sync;
  logic        echo_prev;

  logic [31:0] phase_cnt;   // trigger / timeout / hold-off cycle counter
  logic [31:0] echo_cnt;    // echo high cycles in the current shot
  logic [31:0] width;
  logic        done;
  logic        timeout;
  logic        repeat_en;
  logic        busy;

  logic        ctrl_wr;
  logic        clear_wr;
  logic        start_wr;
  logic        echo_rise;
  logic        timeout_hit;
  logic        phase_clr;
  logic        finish;
  logic        finish_to;

  // The read strobe has no side effects and only ctrl bits 1:0 are defined.
  logic        unused_inputs;
  assign unused_inputs = &{1'b0, read, wr_data[31:2]};

  assign ctrl_wr     = cs & write & (addr == 3'd2);
  assign clear_wr    = cs & write & (addr == 3'd3);
  assign start_wr    = ctrl_wr & wr_data[0];
  assign echo_rise   = echo_sync & ~echo_prev;
  // The phase counter restarts on TRIG exit and keeps running through
  // WAIT_RISE and MEASURE, so it doubles as the combined timeout counter.
  assign timeout_hit = (phase_cnt == TIMEOUT_LAST);
  assign busy        = (state != IDLE);
  assign trig_o      = (state == TRIG);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic and per-cycle control strobes
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first; a path that
    // left one unassigned would infer a latch.
    state_next = state;
    phase_clr  = 1'b0;
    finish     = 1'b0;
    finish_to  = 1'b0;

    unique case (state)
      IDLE: begin
        if (start_wr) begin
          state_next = TRIG;
          phase_clr  = 1'b1;
        end
      end
      TRIG: begin
        if (phase_cnt == TRIG_LAST) begin
          state_next = WAIT_RISE;
          phase_clr  = 1'b1;
        end
      end
      WAIT_RISE: begin
        // Edge detection means an echo already high on entry never qualifies.
        if (timeout_hit) begin
          finish    = 1'b1;
          finish_to = 1'b1;
        end else if (echo_rise) begin
          state_next = MEASURE;
        end
      end
      MEASURE: begin
        // A falling edge in the timeout cycle still counts as a normal result.
        if (!echo_sync) begin
          finish = 1'b1;
        end else if (timeout_hit) begin
          finish    = 1'b1;
          finish_to = 1'b1;
        end
      end
      HOLDOFF: begin
        if (phase_cnt == HOLDOFF_LAST) begin
          state_next = repeat_en ? TRIG : IDLE;
          phase_clr  = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (finish) begin
      state_next = repeat_en ? HOLDOFF : IDLE;
      phase_clr  = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath: echo synchronizer, counters, result and control registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      echo_meta <= 1'b0;
      echo_sync <= 1'b0;
      echo_prev <= 1'b0;
      phase_cnt <= '0;
      echo_cnt  <= '0;
      width     <= '0;
      done      <= 1'b0;
      timeout   <= 1'b0;
      repeat_en <= 1'b0;
    end else begin
      echo_meta <= echo_i;
      echo_sync <= echo_meta;
      echo_prev <= echo_sync;

      if (phase_clr) begin
        phase_cnt <= '0;
      end else if (state != IDLE) begin
        phase_cnt <= phase_cnt + 32'd1;
      end

      // The rising-edge cycle is itself the first high cycle of the pulse.
      if (state == WAIT_RISE) begin
        echo_cnt <= 32'd1;
      end else if (state == MEASURE && echo_sync) begin
        echo_cnt <= echo_cnt + 32'd1;
      end

      if (ctrl_wr) begin
        repeat_en <= wr_data[1];
      end

      // A completion outranks a clear in the same cycle.
      if (finish) begin
        done    <= 1'b1;
        timeout <= finish_to;
        width   <= finish_to ? 32'd0 : echo_cnt;
      end else if (clear_wr || (start_wr && state == IDLE)) begin
        done    <= 1'b0;
        timeout <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read mux
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_data = '0;
    case (addr)
      3'd0:    rd_data = {29'b0, timeout, done, busy};
      3'd1:    rd_data = width;
      default: rd_data = '0;
    endcase
  end

endmodule

// File: tb/tb_range_sensor_core.sv
// -----------------------------------------------------------------------------
// tb_range_sensor_core
//
// Directed bench for range_sensor_core with TRIG_CYCLES=4, TIMEOUT_CYCLES=50,
// HOLDOFF_CYCLES=8. Inputs are driven and outputs sampled around the falling
// clock edge; the DUT acts on the rising edge.
// -----------------------------------------------------------------------------
module tb_range_sensor_core;

  logic        clk;
  logic        reset;
  logic        cs;
  logic        write;
  logic        read;
  logic [2:0]  addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        trig_o;
  logic        echo_i;

  int tests_run;
  int fails;

  range_sensor_core #(
    .TRIG_CYCLES   (4),
    .TIMEOUT_CYCLES(50),
    .HOLDOFF_CYCLES(8)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .cs     (cs),
    .write  (write),
    .read   (read),
    .addr   (addr),
    .wr_data(wr_data),
    .rd_data(rd_data),
    .trig_o (trig_o),
    .echo_i (echo_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic write_reg(input logic [2:0] a, input logic [31:0] d);
    cs      = 1'b1;
    write   = 1'b1;
    addr    = a;
    wr_data = d;
    tick();
    cs      = 1'b0;
    write   = 1'b0;
    addr    = 3'd0;
    wr_data = '0;
  endtask

  task automatic read_reg(input logic [2:0] a, output logic [31:0] d);
    cs   = 1'b1;
    read = 1'b1;
    addr = a;
    #1;
    d    = rd_data;
    cs   = 1'b0;
    read = 1'b0;
  endtask

  // Counts consecutive sampled cycles with trig_o high, bounded.
  task automatic count_trig(output int n);
    n = 0;
    while (trig_o === 1'b1 && n < 100) begin
      n++;
      tick();
    end
  endtask

  task automatic echo_pulse(input int n);
    echo_i = 1'b1;
    repeat (n) tick();
    echo_i = 1'b0;
  endtask

  initial begin
    logic [31:0] st;
    logic [31:0] w;
    int          n;
    int          g;
    int          any;

    tests_run = 0;
    fails     = 0;
    reset     = 1'b1;
    cs        = 1'b0;
    write     = 1'b0;
    read      = 1'b0;
    addr      = 3'd0;
    wr_data   = '0;
    echo_i    = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Reset state
    read_reg(3'd0, st);
    check("reset status", st, 32'h0);
    read_reg(3'd1, w);
    check("reset width", w, 32'h0);
    check("reset trig", {31'b0, trig_o}, 32'h0);

    // Basic measurement: echo high 20 cycles, 5 cycles after trig falls
    write_reg(3'd2, 32'h1);
    count_trig(n);
    check("basic trig len", n, 32'd4);
    read_reg(3'd0, st);
    check("basic busy waiting", st, 32'h1);
    repeat (5) tick();
    echo_pulse(20);
    repeat (6) tick();
    read_reg(3'd0, st);
    check("basic status", st, 32'h2);
    read_reg(3'd1, w);
    check("basic width 20+-1", 32'(w >= 19 && w <= 21), 32'd1);

    // Unmapped addresses and ignored writes
    read_reg(3'd2, st);
    check("read addr2", st, 32'h0);
    read_reg(3'd7, st);
    check("read addr7", st, 32'h0);
    write_reg(3'd4, 32'h1);
    tick();
    read_reg(3'd0, st);
    check("write addr4 ignored", st, 32'h2);
    check("write addr4 no trig", {31'b0, trig_o}, 32'h0);

    // Clear write
    write_reg(3'd3, 32'hdead_beef);
    read_reg(3'd0, st);
    check("clear status", st, 32'h0);

    // Echo stuck high before start: must time out, width 0
    echo_i = 1'b1;
    repeat (4) tick();
    write_reg(3'd2, 32'h1);
    repeat (4 + 50 + 2) tick();
    read_reg(3'd0, st);
    check("stuck status", st, 32'h6);
    read_reg(3'd1, w);
    check("stuck width", w, 32'h0);
    echo_i = 1'b0;
    repeat (4) tick();

    // No echo: timeout exactly 50 cycles after TRIG exits
    write_reg(3'd2, 32'h1);
    read_reg(3'd0, st);
    check("noecho start clears", st, 32'h1);
    repeat (4 + 49) tick();
    read_reg(3'd0, st);
    check("noecho cycle 49", st, 32'h1);
    tick();
    read_reg(3'd0, st);
    check("noecho cycle 50", st, 32'h6);
    read_reg(3'd1, w);
    check("noecho width", w, 32'h0);
    repeat (3) tick();

    // Repeat mode, 10-cycle echo per shot; repeat cleared during the third
    write_reg(3'd2, 32'h3);
    for (int shot = 0; shot < 3; shot++) begin
      count_trig(n);
      check($sformatf("rep%0d trig len", shot), n, 32'd4);
      repeat (3) tick();
      if (shot < 2) begin
        echo_pulse(10);
        g = 0;
        while (trig_o !== 1'b1 && g < 100) begin
          g++;
          tick();
        end
        check($sformatf("rep%0d next trig", shot), {31'b0, trig_o}, 32'h1);
        check($sformatf("rep%0d gap>=8", shot), 32'(g >= 8), 32'd1);
        read_reg(3'd0, st);
        check($sformatf("rep%0d done kept", shot), st, 32'h3);
        read_reg(3'd1, w);
        check($sformatf("rep%0d width", shot), 32'(w >= 9 && w <= 11), 32'd1);
      end else begin
        echo_i = 1'b1;
        repeat (5) tick();
        write_reg(3'd2, 32'h0);
        repeat (4) tick();
        echo_i = 1'b0;
      end
    end
    any = 0;
    repeat (20) begin
      if (trig_o === 1'b1) any++;
      tick();
    end
    check("rep stop no trig", any, 32'd0);
    read_reg(3'd0, st);
    check("rep stop status", st, 32'h2);
    read_reg(3'd1, w);
    check("rep stop width", 32'(w >= 9 && w <= 11), 32'd1);

    // Start while busy is ignored: one trig pulse only
    write_reg(3'd2, 32'h1);
    write_reg(3'd2, 32'h1);
    count_trig(n);
    check("busy start trig rest", n, 32'd3);
    repeat (2) tick();
    echo_pulse(6);
    any = 0;
    repeat (30) begin
      if (trig_o === 1'b1) any++;
      tick();
    end
    check("busy start no retrig", any, 32'd0);
    read_reg(3'd0, st);
    check("busy start status", st, 32'h2);
    read_reg(3'd1, w);
    check("busy start width", 32'(w >= 5 && w <= 7), 32'd1);

    // Reset during MEASURE: all status 0, no done afterwards
    write_reg(3'd2, 32'h1);
    count_trig(n);
    repeat (2) tick();
    echo_i = 1'b1;
    repeat (6) tick();
    reset = 1'b1;
    tick();
    check("rst meas trig", {31'b0, trig_o}, 32'h0);
    read_reg(3'd0, st);
    check("rst meas status", st, 32'h0);
    read_reg(3'd1, w);
    check("rst meas width", w, 32'h0);
    reset = 1'b0;
    repeat (5) tick();
    echo_i = 1'b0;
    repeat (10) tick();
    read_reg(3'd0, st);
    check("rst meas no done", st, 32'h0);

    // Reset during TRIG drops trig_o on the next edge
    write_reg(3'd2, 32'h1);
    tick();
    check("rst trig before", {31'b0, trig_o}, 32'h1);
    reset = 1'b1;
    tick();
    check("rst trig after", {31'b0, trig_o}, 32'h0);
    reset = 1'b0;
    tick();
    read_reg(3'd0, st);
    check("rst trig status", st, 32'h0);

    // Clear write in the same cycle as a timeout completion: done stays 1
    write_reg(3'd2, 32'h1);
    repeat (4 + 49) tick();
    read_reg(3'd0, st);
    check("coincide before", st, 32'h1);
    write_reg(3'd3, 32'h0);
    read_reg(3'd0, st);
    check("coincide done kept", st, 32'h6);
    write_reg(3'd3, 32'h0);
    read_reg(3'd0, st);
    check("coincide later clear", st, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/range_sensor_core.md
RANGE_SENSOR_CORE -- requirements
Module: range_sensor_core

Interface
REQ-001 SHALL have parameter TRIG_CYCLES, default 1000, trigger pulse width in clk cycles (10 us at 100 MHz).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 3_000_000, maximum wait for echo rise plus echo high time (30 ms).
REQ-003 SHALL have parameter HOLDOFF_CYCLES, default 6_000_000, minimum idle gap between measurements in repeat mode (60 ms).
REQ-004 clk  input  1  system clock; the block uses one clock only.
REQ-005 reset  input  1  reset; synchronous and active-high.
REQ-006 cs  input  1  slot select from the subsystem controller.
REQ-007 write  input  1  write strobe; qualified by cs.
REQ-008 read  input  1  read strobe; qualified by cs; causes no side effects.
REQ-009 addr  input  3  register address.
REQ-010 wr_data  input  32  write data.
REQ-011 rd_data  output  32  read data.
REQ-012 trig_o  output  1  trigger pin to the sensor.
REQ-013 echo_i  input  1  echo pin from the sensor; asynchronous.

Function
REQ-014 SHALL pass echo_i through a 2-flop synchronizer; all echo logic SHALL use the synchronized value and its registered previous value for edge detection.
REQ-015 Register map SHALL be as follows.
- addr 0 read: status {29'b0, timeout, done, busy}.
- addr 1 read: width, 32-bit echo high time in clk cycles.
- addr 2 write: ctrl; bit0 = start (self-clearing), bit1 = repeat enable (sticky).
- addr 3 write: any value clears done and timeout.
- All other addresses read 0; writes to them are ignored.
REQ-016 rd_data SHALL be a combinational mux of addr and is valid whenever it is addressed, independent of read.
REQ-017 FSM states SHALL be IDLE, TRIG, WAIT_RISE, MEASURE and HOLDOFF; busy = (state != IDLE).
REQ-018 IDLE -> TRIG on (cs & write & addr==2 & wr_data[0]); the same write SHALL clear done and timeout. A start written in any other state SHALL be ignored, but the repeat bit SHALL still update.
REQ-019 TRIG SHALL hold trig_o = 1 for exactly TRIG_CYCLES cycles, starting the cycle after the start write, and then go to WAIT_RISE; trig_o SHALL be 0 in all other states.
REQ-020 WAIT_RISE -> MEASURE on a synchronized echo rising edge. An echo level that is already high on entry SHALL NOT count; the block waits for a true rising edge.
REQ-021 MEASURE SHALL increment a 32-bit counter on each cycle the synchronized echo is high. On the first synchronized-low cycle it SHALL load width with the count, set done and leave the state.
REQ-022 Timeout handling SHALL work as follows.
- One timeout counter SHALL run through WAIT_RISE and MEASURE combined.
- When it reaches TIMEOUT_CYCLES, the block SHALL set timeout and done, load width with 0 and leave the state.
- If the falling edge and the timeout occur in the same cycle, the falling edge SHALL win (normal completion).
REQ-023 On leaving MEASURE or WAIT_RISE, the next state SHALL be HOLDOFF if repeat = 1, otherwise IDLE.
REQ-024 HOLDOFF SHALL last HOLDOFF_CYCLES cycles and then go to TRIG if repeat is still 1, otherwise to IDLE. Clearing repeat at any time SHALL stop the block after the current measurement completes.
REQ-025 done and timeout SHALL stay set until a clear write (addr 3) or the next accepted start. An auto-repeat trigger SHALL NOT clear them; each new completion overwrites width and timeout.
REQ-026 A clear write in the same cycle as a completion SHALL leave done = 1 (the completion wins).
REQ-027 The measured width SHALL equal the number of clk cycles echo_i is high, to within ±1 cycle of synchronizer skew; the counter SHALL NOT wrap, because the timeout caps it.

Reset
REQ-028 On reset the state SHALL be IDLE and the following SHALL all be 0:
- trig_o, busy, done, timeout, repeat
- width and all counters
- synchronizer flops
REQ-029 Reset asserted mid-measurement SHALL abort immediately: trig_o = 0 on the next edge and no done is produced.

Verification (TRIG_CYCLES=4, TIMEOUT_CYCLES=50, HOLDOFF_CYCLES=8)
REQ-030 Basic measurement: write addr2=0x1; echo high 20 cycles, 5 cycles after trig falls.
- trig_o is high exactly 4 cycles.
- width = 20 (±1), done = 1, timeout = 0, busy returns to 0.
REQ-031 No echo: start and never raise echo.
- done = 1, timeout = 1, width = 0, exactly 50 cycles after TRIG exits.
REQ-032 Echo stuck high: echo held high from before the start.
- No MEASURE entry; result is timeout.
REQ-033 Repeat mode: write addr2=0x3 with echo high 10 cycles per shot.
- Successive trig pulses are separated by at least 8 idle cycles after each completion.
- Write addr2=0x0: the block stops after the current shot; busy = 0.
REQ-034 Busy and clear interactions:
- A start while busy is ignored: one trig pulse only.
- A clear write coinciding with a completion leaves done = 1.
- Reset during MEASURE leaves all status 0 and trig_o = 0.
